// File: rtl/tx_bit_mod.sv
// Byte-serialising FSK/BPSK modulator feeding the TX NCO control and phase words.
// Each byte is framed as a start bit, 8 data bits LSB first and a stop bit; an alternating preamble leads every burst.
module tx_bit_mod #(
  parameter int unsigned BIT_PERIOD    = 64,
  parameter logic [15:0] F0_WORD       = 16'h2C00,
  parameter logic [15:0] F1_WORD       = 16'h2E00,
  parameter logic [15:0] CARRIER_WORD  = 16'h2D00,
  parameter int unsigned PREAMBLE_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] control_word,
  output logic [15:0] phase_control_word,
  output logic        tx_active,
  output logic        bit_strobe
);

  localparam int unsigned CW       = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned IDX_MAX  = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int unsigned IW       = $clog2(IDX_MAX);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [IW-1:0] PRE_LAST  = IW'(PREAMBLE_BITS - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(7);

  typedef enum logic [2:0] {IDLE, PREAMBLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [7:0]    data_q, data_n;
  logic          mode_q, mode_n;
  logic          bit_n;
  logic [15:0]   cw_n, pw_n;
  logic          wrap, xfer;

  assign wrap       = (cnt == CNT_LAST);
  // Reset input gates ready so nothing is offered while rst is held low.
  assign in_ready   = rst && ((state == IDLE) || ((state == STOP) && wrap));
  assign xfer       = in_valid && in_ready;
  assign tx_active  = (state != IDLE);
  assign bit_strobe = (state != IDLE) && (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = data_q;
    mode_n  = mode_q;
    if (state != IDLE) cnt_n = wrap ? '0 : cnt + CW'(1);
    case (state)
      IDLE: begin
        if (xfer) begin
          state_n = PREAMBLE;
          cnt_n   = '0;
          idx_n   = '0;
          data_n  = in_data;
          mode_n  = mode;
        end
      end
      PREAMBLE: begin
        if (wrap) begin
          if (idx == PRE_LAST) begin
            state_n = START;
            idx_n   = '0;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      START: begin
        if (wrap) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (wrap) begin
          if (idx == DATA_LAST) begin
            state_n = STOP;
            idx_n   = '0;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      STOP: begin
        if (wrap) begin
          if (xfer) begin
            state_n = START;
            data_n  = in_data;
            mode_n  = mode;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Output words are computed from the next state so they line up with the first cycle of each bit.
    case (state_n)
      PREAMBLE: bit_n = ~idx_n[0];
      START:    bit_n = 1'b0;
      DATA:     bit_n = data_n[idx_n[2:0]];
      default:  bit_n = 1'b1;
    endcase

    cw_n = F1_WORD;
    pw_n = '0;
    if (state_n != IDLE) begin
      if (mode_n) begin
        cw_n = CARRIER_WORD;
        pw_n = bit_n ? 16'h0000 : 16'h8000;
      end else begin
        cw_n = bit_n ? F1_WORD : F0_WORD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      cnt                <= '0;
      idx                <= '0;
      data_q             <= '0;
      mode_q             <= 1'b0;
      control_word       <= F1_WORD;
      phase_control_word <= '0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      idx                <= idx_n;
      data_q             <= data_n;
      mode_q             <= mode_n;
      control_word       <= cw_n;
      phase_control_word <= pw_n;
    end
  end

endmodule

// File: tb/tb_tx_bit_mod.sv
// Self-checking bench for tx_bit_mod: table-driven frames, directed corner sequences and a randomized run against a frame-list model.
module tb_tx_bit_mod;

  localparam int BP = 4;
  localparam int PB = 2;

  logic        clk = 1'b0;
  logic        rst, mode, in_valid, in_ready, tx_active, bit_strobe;
  logic [7:0]  in_data;
  logic [15:0] control_word, phase_control_word;

  always #5 clk = ~clk;

  tx_bit_mod #(
    .BIT_PERIOD(BP),
    .PREAMBLE_BITS(PB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .control_word(control_word),
    .phase_control_word(phase_control_word),
    .tx_active(tx_active),
    .bit_strobe(bit_strobe)
  );

  int total = 0;
  int bad   = 0;

  // Model: the current burst is a plain list of bits; m_t counts cycles since the burst began.
  bit m_active;
  int m_t;
  bit m_mode;
  bit m_bits[$];
  bit last_xfer;

  typedef struct packed {
    logic [7:0]        data;
    logic              md;
    logic [11:0][15:0] cw;
    logic [11:0][15:0] pw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build(input logic [7:0] d, input bit pre);
    m_bits.delete();
    if (pre) for (int i = 0; i < PB; i++) m_bits.push_back(i % 2 == 0);
    m_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) m_bits.push_back(d[i]);
    m_bits.push_back(1'b1);
  endfunction

  task automatic cycle();
    bit          exp_rdy, xf, md, b;
    logic [7:0]  d;
    logic [15:0] ecw, epw;
    #1;
    exp_rdy = rst && (!m_active || (m_t == m_bits.size() * BP - 1));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    xf = in_valid && exp_rdy;
    d  = in_data;
    md = mode;
    last_xfer = xf;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_active = 0;
      m_mode   = 0;
      m_t      = 0;
    end else if (m_active) begin
      if (m_t == m_bits.size() * BP - 1) begin
        if (xf) begin
          build(d, 0);
          m_mode = md;
          m_t    = 0;
        end else begin
          m_active = 0;
        end
      end else begin
        m_t++;
      end
    end else if (xf) begin
      build(d, 1);
      m_mode   = md;
      m_t      = 0;
      m_active = 1;
    end
    ecw = 16'h2E00;
    epw = 16'h0000;
    if (m_active) begin
      b = m_bits[m_t / BP];
      if (m_mode) begin
        ecw = 16'h2D00;
        epw = b ? 16'h0000 : 16'h8000;
      end else begin
        ecw = b ? 16'h2E00 : 16'h2C00;
      end
    end
    chk("tx_active", 32'(tx_active), 32'(m_active));
    chk("bit_strobe", 32'(bit_strobe), 32'(m_active && (m_t % BP == 0)));
    chk("control_word", 32'(control_word), 32'(ecw));
    chk("phase_word", 32'(phase_control_word), 32'(epw));
  endtask

  initial begin
    vec_t vecs[2];
    int   act_cnt, stb_cnt, k, first_k, last_k, acc, bpsk_seen;

    // Words listed stop bit first, down to preamble bit 0.
    vecs[0].data = 8'hA5;
    vecs[0].md   = 1'b0;
    vecs[0].cw   = {16'h2E00, 16'h2E00, 16'h2C00, 16'h2E00, 16'h2C00, 16'h2C00,
                    16'h2E00, 16'h2C00, 16'h2E00, 16'h2C00, 16'h2C00, 16'h2E00};
    vecs[0].pw   = '0;
    vecs[1].data = 8'h01;
    vecs[1].md   = 1'b1;
    vecs[1].cw   = {12{16'h2D00}};
    vecs[1].pw   = {16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                    16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h0000};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0;
    m_active = 0; m_t = 0; m_mode = 0; last_xfer = 0;

    // Reset and release.
    repeat (3) cycle();
    chk("rst_cw", 32'(control_word), 32'h2E00);
    chk("rst_pw", 32'(phase_control_word), 32'h0);
    chk("rst_active", 32'(tx_active), 32'h0);
    rst = 1'b1;
    #1;
    chk("rdy_after_rst", 32'(in_ready), 32'h1);
    cycle();

    // Table-driven single-byte bursts.
    foreach (vecs[v]) begin
      in_data = vecs[v].data; mode = vecs[v].md; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      act_cnt = 0; stb_cnt = 0;
      for (int i = 0; i < 12 * BP; i++) begin
        chk("tbl_cw", 32'(control_word), 32'(vecs[v].cw[i / BP]));
        chk("tbl_pw", 32'(phase_control_word), 32'(vecs[v].pw[i / BP]));
        if (tx_active) act_cnt++;
        if (bit_strobe) stb_cnt++;
        cycle();
      end
      chk("tbl_end_idle", 32'(tx_active), 32'h0);
      chk("tbl_active_len", 32'(act_cnt), 32'(12 * BP));
      chk("tbl_strobes", 32'(stb_cnt), 32'd12);
      repeat (3) cycle();
    end

    // Back-to-back bytes with in_valid held: 00 then FF, no preamble on the second.
    in_data = 8'h00; mode = 1'b0; in_valid = 1'b1;
    acc = 0; act_cnt = 0; k = -1; first_k = -1; last_k = -1;
    for (int i = 0; i < 120; i++) begin
      cycle();
      if (last_xfer) begin
        acc++;
        if (acc == 1) begin in_data = 8'hFF; k = 0; end
        if (acc == 2) in_valid = 1'b0;
      end else if (k >= 0) begin
        k++;
      end
      if (tx_active) begin
        act_cnt++;
        if (first_k < 0) first_k = i;
        last_k = i;
      end
      if (k == 12 * BP) chk("b2b_start_bit", 32'(control_word), 32'h2C00);
    end
    chk("b2b_accepts", 32'(acc), 32'd2);
    chk("b2b_active_len", 32'(act_cnt), 32'(22 * BP));
    chk("b2b_continuous", 32'(last_k - first_k + 1), 32'(act_cnt));

    // Reset during data bit 3 aborts; the next byte gets a full preamble.
    in_data = 8'h5A; mode = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (25) cycle();
    rst = 1'b0;
    cycle();
    chk("abort_idle", 32'(tx_active), 32'h0);
    chk("abort_cw", 32'(control_word), 32'h2E00);
    rst = 1'b1;
    stb_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (bit_strobe) stb_cnt++;
    end
    chk("abort_no_strobe", 32'(stb_cnt), 32'h0);
    in_data = 8'h3C; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("restart_pre0", 32'(control_word), 32'h2E00);
    repeat (BP) cycle();
    chk("restart_pre1", 32'(control_word), 32'h2C00);
    repeat (50) cycle();

    // Mode switched mid-frame must not affect the frame in flight.
    in_data = 8'hC3; mode = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    mode = 1'b1;
    bpsk_seen = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (control_word == 16'h2D00) bpsk_seen++;
    end
    chk("mode_hold", 32'(bpsk_seen), 32'h0);
    in_data = 8'h81; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("mode_next_bpsk", 32'(control_word), 32'h2D00);
    repeat (50) cycle();

    // Randomized traffic, mode jitter and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      mode     = 1'($urandom);
      rst      = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst = 1'b1; in_valid = 1'b0;
    repeat (60) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
